// File: rtl/mips_pipe_pkg.sv
// Shared types and constants for the MIPS pipeline control blocks.
// The action enum names the resolved priority case for one cycle.
package mips_pipe_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    FREEZE = 2'd1,
    HUNG   = 2'd2
  } hz_state_e;

  typedef enum logic [2:0] {
    ACT_RESET  = 3'd0,
    ACT_FREEZE = 3'd1,
    ACT_BRANCH = 3'd2,
    ACT_STALL  = 3'd3,
    ACT_RUN    = 3'd4
  } hz_action_e;

  localparam int unsigned          REG_AW   = 5;
  localparam logic [REG_AW-1:0]    ZERO_REG = 5'd0;
  localparam int unsigned          CNT_W    = 16;

endpackage

// File: rtl/sat_counter16.sv
// Event counter that holds at all-ones instead of wrapping.
module sat_counter16
  import mips_pipe_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_count
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_inc && (r_count != '1)) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/hazard_controller.sv
// Stall/flush/freeze sequencer for the 5-stage pipeline: load-use and
// mul/div hazards, MEM-stage branch redirects, dmem freeze and hang detection.
module hazard_controller
  import mips_pipe_pkg::*;
#(
  parameter int unsigned MD_LATENCY  = 8,
  parameter int unsigned MEM_TIMEOUT = 64
)
(
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rt,
  input  logic              id_is_md,
  input  logic              id_reads_hilo,
  input  logic              idex_mem_read,
  input  logic [REG_AW-1:0] idex_rt,
  input  logic              mem_branch_taken,
  input  logic              dmem_busy,
  output logic              pc_write,
  output logic              pc_sel_branch,
  output logic              ifid_write,
  output logic              ifid_flush,
  output logic              idex_flush,
  output logic              exmem_flush,
  output logic              pipe_hold,
  output logic              md_busy,
  output logic              mem_timeout,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [CNT_W-1:0]  freeze_cycles,
  output logic [CNT_W-1:0]  flush_events
);

  hz_state_e  r_state;
  hz_action_e w_action;
  logic [3:0] r_md_cnt;
  logic [7:0] r_wait_cnt;
  logic [7:0] w_wait_inc;
  logic       w_wait_hit;
  logic       w_freeze;
  logic       w_load_use;
  logic       w_md_hz;
  logic       w_hazard;
  logic       w_md_issue;

  assign w_wait_inc = r_wait_cnt + 8'd1;
  assign w_wait_hit = (w_wait_inc == 8'(MEM_TIMEOUT));
  assign w_freeze   = dmem_busy || (r_state == HUNG);

  assign w_load_use = id_valid && idex_mem_read && (idex_rt != ZERO_REG) &&
                      ((idex_rt == id_rs) || (id_uses_rt && (idex_rt == id_rt)));
  assign w_md_hz    = id_valid && (id_is_md || id_reads_hilo) && (r_md_cnt != '0);
  assign w_hazard   = w_load_use || w_md_hz;

  // A taken branch seen during freeze is simply not acted on; the MEM stage
  // is held, so the branch is still presented once the freeze lifts.
  always_comb begin
    w_action = ACT_RUN;
    if (reset) begin
      w_action = ACT_RESET;
    end else if (w_freeze) begin
      w_action = ACT_FREEZE;
    end else if (mem_branch_taken) begin
      w_action = ACT_BRANCH;
    end else if (w_hazard) begin
      w_action = ACT_STALL;
    end
  end

  always_comb begin
    pc_write      = 1'b0;
    pc_sel_branch = 1'b0;
    ifid_write    = 1'b0;
    ifid_flush    = 1'b0;
    idex_flush    = 1'b0;
    exmem_flush   = 1'b0;
    pipe_hold     = 1'b0;
    case (w_action)
      ACT_RESET, ACT_FREEZE: begin
        pipe_hold = 1'b1;
      end
      ACT_BRANCH: begin
        pc_sel_branch = 1'b1;
        pc_write      = 1'b1;
        ifid_write    = 1'b1;
        ifid_flush    = 1'b1;
        idex_flush    = 1'b1;
        exmem_flush   = 1'b1;
      end
      ACT_STALL: begin
        idex_flush = 1'b1;
      end
      default: begin
        pc_write   = 1'b1;
        ifid_write = 1'b1;
      end
    endcase
  end

  assign w_md_issue = (w_action == ACT_RUN) && id_valid && id_is_md;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_md_cnt <= '0;
    end else if (w_md_issue) begin
      r_md_cnt <= 4'(MD_LATENCY);
    end else if (r_md_cnt != '0) begin
      r_md_cnt <= r_md_cnt - 4'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= RUN;
      r_wait_cnt <= '0;
    end else begin
      r_wait_cnt <= dmem_busy ? w_wait_inc : '0;
      case (r_state)
        RUN: begin
          if (dmem_busy) r_state <= FREEZE;
        end
        FREEZE: begin
          if (!dmem_busy)      r_state <= RUN;
          else if (w_wait_hit) r_state <= HUNG;
        end
        HUNG: begin
          r_state <= HUNG;
        end
        default: begin
          r_state <= RUN;
        end
      endcase
    end
  end

  assign md_busy     = (r_md_cnt != '0);
  assign mem_timeout = (r_state == HUNG);

  sat_counter16 u_stall_cnt (
    .i_clk   (clk),
    .i_rst   (reset),
    .i_inc   (w_action == ACT_STALL),
    .o_count (stall_cycles)
  );

  sat_counter16 u_freeze_cnt (
    .i_clk   (clk),
    .i_rst   (reset),
    .i_inc   (w_action == ACT_FREEZE),
    .o_count (freeze_cycles)
  );

  sat_counter16 u_flush_cnt (
    .i_clk   (clk),
    .i_rst   (reset),
    .i_inc   (w_action == ACT_BRANCH),
    .o_count (flush_events)
  );

endmodule

// File: tb/tb_hazard_controller.sv
// Bench for hazard_controller: directed scenarios plus random traffic,
// all checked against a cycle-level priority model of the control rules.
module tb_hazard_controller;

  localparam int unsigned LAT = 4;
  localparam int unsigned TO  = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        id_valid, id_uses_rt, id_is_md, id_reads_hilo;
  logic [4:0]  id_rs, id_rt, idex_rt;
  logic        idex_mem_read, mem_branch_taken, dmem_busy;
  logic        pc_write, pc_sel_branch, ifid_write, ifid_flush, idex_flush;
  logic        exmem_flush, pipe_hold, md_busy, mem_timeout;
  logic [15:0] stall_cycles, freeze_cycles, flush_events;

  always #5 clk = ~clk;

  hazard_controller #(.MD_LATENCY(LAT), .MEM_TIMEOUT(TO)) dut (
    .clk              (clk),
    .reset            (reset),
    .id_valid         (id_valid),
    .id_rs            (id_rs),
    .id_rt            (id_rt),
    .id_uses_rt       (id_uses_rt),
    .id_is_md         (id_is_md),
    .id_reads_hilo    (id_reads_hilo),
    .idex_mem_read    (idex_mem_read),
    .idex_rt          (idex_rt),
    .mem_branch_taken (mem_branch_taken),
    .dmem_busy        (dmem_busy),
    .pc_write         (pc_write),
    .pc_sel_branch    (pc_sel_branch),
    .ifid_write       (ifid_write),
    .ifid_flush       (ifid_flush),
    .idex_flush       (idex_flush),
    .exmem_flush      (exmem_flush),
    .pipe_hold        (pipe_hold),
    .md_busy          (md_busy),
    .mem_timeout      (mem_timeout),
    .stall_cycles     (stall_cycles),
    .freeze_cycles    (freeze_cycles),
    .flush_events     (flush_events)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: plain integers, no encoding shared with the DUT.
  int m_md, m_wait, m_stall, m_freeze, m_flush;
  bit m_hung;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int sat16(input int v);
    return (v >= 65535) ? 65535 : v + 1;
  endfunction

  // 1=reset 2=freeze 3=branch 4=stall 5=run
  function automatic int act_now();
    bit lu, mh;
    lu = id_valid && idex_mem_read && (idex_rt != 0) &&
         ((idex_rt == id_rs) || (id_uses_rt && (idex_rt == id_rt)));
    mh = id_valid && (id_is_md || id_reads_hilo) && (m_md != 0);
    if (reset)                 return 1;
    if (dmem_busy || m_hung)   return 2;
    if (mem_branch_taken)      return 3;
    if (lu || mh)              return 4;
    return 5;
  endfunction

  task automatic model_reset();
    m_md = 0; m_wait = 0; m_stall = 0; m_freeze = 0; m_flush = 0; m_hung = 0;
  endtask

  task automatic model_update();
    int a;
    a = act_now();
    if (a == 5 && id_valid && id_is_md) m_md = LAT;
    else if (m_md > 0)                  m_md--;
    if (a == 2) m_freeze = sat16(m_freeze);
    if (a == 3) m_flush  = sat16(m_flush);
    if (a == 4) m_stall  = sat16(m_stall);
    if (dmem_busy) begin
      if (!m_hung && (m_wait + 1 == TO)) m_hung = 1;
      m_wait = (m_wait + 1) % 256;
    end else begin
      m_wait = 0;
    end
  endtask

  task automatic check_outputs();
    int a;
    logic [6:0] exp_ctrl, got_ctrl;
    a = act_now();
    exp_ctrl = {(a == 3 || a == 5), (a == 3), (a == 3 || a == 5), (a == 3),
                (a == 3 || a == 4), (a == 3), (a <= 2)};
    got_ctrl = {pc_write, pc_sel_branch, ifid_write, ifid_flush,
                idex_flush, exmem_flush, pipe_hold};
    check("ctrl", 32'(got_ctrl), 32'(exp_ctrl));
    check("md_busy", 32'(md_busy), 32'(m_md != 0));
    check("mem_timeout", 32'(mem_timeout), 32'(m_hung));
    check("stall_cycles", 32'(stall_cycles), 32'(m_stall));
    check("freeze_cycles", 32'(freeze_cycles), 32'(m_freeze));
    check("flush_events", 32'(flush_events), 32'(m_flush));
  endtask

  task automatic step();
    #1;
    check_outputs();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    #1;
    check_outputs();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic idle();
    id_valid = 0; id_rs = 0; id_rt = 0; id_uses_rt = 0; id_is_md = 0;
    id_reads_hilo = 0; idex_mem_read = 0; idex_rt = 0;
    mem_branch_taken = 0; dmem_busy = 0;
  endtask

  initial begin
    idle();
    model_reset();
    #1;
    do_reset();

    // Load-use on rs, then the load moves on, then a load to $zero.
    id_valid = 1; id_rs = 5'd8; idex_mem_read = 1; idex_rt = 5'd8;
    step();
    idex_mem_read = 0;
    step();
    check("lu_stall_count", 32'(stall_cycles), 32'd1);
    idex_mem_read = 1; idex_rt = 5'd0; id_rs = 5'd0;
    step();
    check("lu_zero_no_stall", 32'(pc_write), 32'd1);
    check("lu_zero_count", 32'(stall_cycles), 32'd1);

    // Branch beats a simultaneous load-use.
    idex_rt = 5'd8; id_rs = 5'd8; mem_branch_taken = 1;
    step();
    check("br_flush_count", 32'(flush_events), 32'd1);
    check("br_no_stall", 32'(stall_cycles), 32'd1);
    idle();

    // Freeze holds a taken branch for three cycles, then it redirects.
    do_reset();
    mem_branch_taken = 1; dmem_busy = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("frz_hold", 32'(pipe_hold), 32'd1);
      check("frz_no_flush", 32'(exmem_flush), 32'd0);
    end
    dmem_busy = 0;
    step();
    check("frz_cycles", 32'(freeze_cycles), 32'd3);
    check("frz_redirect", 32'(flush_events), 32'd1);
    idle();

    // mult, then mflo waits out the countdown.
    do_reset();
    id_valid = 1; id_is_md = 1;
    step();
    check("md_issue_busy", 32'(md_busy), 32'd1);
    id_is_md = 0; id_reads_hilo = 1;
    for (int i = 0; i < 5; i++) step();
    check("md_stall_count", 32'(stall_cycles), 32'd4);
    check("md_done", 32'(md_busy), 32'd0);
    idle();

    // Busy one cycle short of the timeout recovers.
    do_reset();
    dmem_busy = 1;
    for (int i = 0; i < 7; i++) step();
    dmem_busy = 0;
    step();
    check("to_short_flag", 32'(mem_timeout), 32'd0);
    check("to_short_run", 32'(pc_write), 32'd1);

    // Exactly the timeout hangs the pipe.
    dmem_busy = 1;
    for (int i = 0; i < 8; i++) step();
    check("to_hit_flag", 32'(mem_timeout), 32'd1);
    dmem_busy = 0;
    step();
    check("to_sticky", 32'(mem_timeout), 32'd1);
    check("to_still_hold", 32'(pipe_hold), 32'd1);

    // Reset off the clock edge while hung.
    #2;
    do_reset();
    check("hung_rst_flag", 32'(mem_timeout), 32'd0);
    check("hung_rst_frz", 32'(freeze_cycles), 32'd0);
    step();
    check("hung_rst_pcw", 32'(pc_write), 32'd1);

    // Saturate freeze_cycles.
    dmem_busy = 1;
    for (int i = 0; i < 70000; i++) begin
      @(posedge clk);
      model_update();
    end
    @(negedge clk);
    check("sat_freeze", 32'(freeze_cycles), 32'h0000ffff);
    check_outputs();
    idle();
    do_reset();

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      id_valid         = ($urandom_range(0, 3) != 0);
      id_rs            = 5'($urandom_range(0, 3));
      id_rt            = 5'($urandom_range(0, 3));
      id_uses_rt       = 1'($urandom_range(0, 1));
      id_is_md         = ($urandom_range(0, 5) == 0);
      id_reads_hilo    = ($urandom_range(0, 5) == 0);
      idex_mem_read    = 1'($urandom_range(0, 1));
      idex_rt          = 5'($urandom_range(0, 3));
      mem_branch_taken = ($urandom_range(0, 7) == 0);
      dmem_busy        = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 299) == 0) do_reset();
      else                             step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
